// File: rtl/dcm_lock_ctrl.sv
// Reset and lock sequencer for the DCM_SP 100 MHz -> 24 MHz clock generator.
// Runs on CLKIN; retries on lock timeout and latches a fault after repeated failures.
module dcm_lock_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT    = 50000,
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned MAX_RETRIES     = 7,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLK_IN1,
    input  logic       RESET_N,
    input  logic       DCM_LOCKED,
    input  logic [7:0] DCM_STATUS,
    input  logic       FORCE_RELOCK,
    output logic       DCM_RESET,
    output logic       CLK_OK,
    output logic       SYS_RESET_N,
    output logic [3:0] RETRY_CNT,
    output logic       FAULT
);

    localparam logic [2:0] StRstHold  = 3'd0;
    localparam logic [2:0] StWaitLock = 3'd1;
    localparam logic [2:0] StSettle   = 3'd2;
    localparam logic [2:0] StRun      = 3'd3;
    localparam logic [2:0] StFail     = 3'd4;

    localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       RetryMax    = 4'(MAX_RETRIES);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dcm_reset_q, dcm_reset_d;
    logic             clk_ok_q, clk_ok_d;
    logic [3:0]       retry_q, retry_d;
    logic             fault_q, fault_d;
    logic [2:0]       sync_m, sync_s;
    logic [3:0]       retry_inc;
    logic             lock_s, stop_s;
    logic             unused_status;

    assign unused_status = ^{DCM_STATUS[7:3], DCM_STATUS[0]};

    // Bit 0: LOCKED, bit 1: CLKIN stopped, bit 2: CLKFX stopped.
    always_ff @(posedge CLK_IN1) begin
        if (!RESET_N) begin
            sync_m <= '0;
            sync_s <= '0;
        end else begin
            sync_m <= {DCM_STATUS[2], DCM_STATUS[1], DCM_LOCKED};
            sync_s <= sync_m;
        end
    end

    assign lock_s    = sync_s[0];
    assign stop_s    = sync_s[1] | sync_s[2];
    assign retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dcm_reset_d = dcm_reset_q;
        clk_ok_d    = clk_ok_q;
        retry_d     = retry_q;
        fault_d     = fault_q;
        unique case (state_q)
            StRstHold: begin
                dcm_reset_d = 1'b1;
                clk_ok_d    = 1'b0;
                if (cnt_q == HoldLast) begin
                    state_d     = StWaitLock;
                    cnt_d       = '0;
                    dcm_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock, StSettle: begin
                // Lock wins over a coincident timeout; loss/stop in SETTLE counts as a failure.
                if ((state_q == StWaitLock && !lock_s && cnt_q == TimeoutLast) ||
                    (state_q == StSettle && (!lock_s || stop_s))) begin
                    retry_d     = retry_inc;
                    cnt_d       = '0;
                    dcm_reset_d = 1'b1;
                    if (retry_inc == RetryMax) begin
                        state_d = StFail;
                        fault_d = 1'b1;
                    end else begin
                        state_d = StRstHold;
                    end
                end else if (state_q == StWaitLock && lock_s) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else if (state_q == StSettle && cnt_q == SettleLast) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    clk_ok_d = 1'b1;
                    retry_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_s || stop_s || FORCE_RELOCK) begin
                    state_d     = StRstHold;
                    cnt_d       = '0;
                    dcm_reset_d = 1'b1;
                    clk_ok_d    = 1'b0;
                end
            end
            StFail: begin
                dcm_reset_d = 1'b1;
                clk_ok_d    = 1'b0;
                fault_d     = 1'b1;
                if (FORCE_RELOCK) begin
                    state_d = StRstHold;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d     = StRstHold;
                cnt_d       = '0;
                dcm_reset_d = 1'b1;
                clk_ok_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_IN1) begin
        if (!RESET_N) begin
            state_q     <= StRstHold;
            cnt_q       <= '0;
            dcm_reset_q <= 1'b1;
            clk_ok_q    <= 1'b0;
            retry_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcm_reset_q <= dcm_reset_d;
            clk_ok_q    <= clk_ok_d;
            retry_q     <= retry_d;
            fault_q     <= fault_d;
        end
    end

    assign DCM_RESET   = dcm_reset_q;
    assign CLK_OK      = clk_ok_q;
    assign SYS_RESET_N = clk_ok_q;
    assign RETRY_CNT   = retry_q;
    assign FAULT       = fault_q;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Scoreboard bench for dcm_lock_ctrl: expected latencies/values are queued as stimulus
// is driven and compared when the corresponding output event is observed.
module tb_dcm_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dcm_locked = 1'b0;
    logic [7:0] dcm_status = 8'h00;
    logic       force_relock = 1'b0;
    logic       dcm_reset, clk_ok, sys_reset_n, fault;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    dcm_lock_ctrl #(
        .RST_HOLD_CYCLES(8),
        .LOCK_TIMEOUT   (100),
        .SETTLE_CYCLES  (16),
        .MAX_RETRIES    (3),
        .CNT_W          (20)
    ) dut (
        .CLK_IN1     (clk),
        .RESET_N     (reset_n),
        .DCM_LOCKED  (dcm_locked),
        .DCM_STATUS  (dcm_status),
        .FORCE_RELOCK(force_relock),
        .DCM_RESET   (dcm_reset),
        .CLK_OK      (clk_ok),
        .SYS_RESET_N (sys_reset_n),
        .RETRY_CNT   (retry_cnt),
        .FAULT       (fault)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input int obs);
        if (exp_q.size() == 0) check_val({tag, "_sb_underflow"}, obs, -1);
        else check_val(tag, obs, exp_q.pop_front());
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return dcm_reset;
            1:       return clk_ok;
            default: return fault;
        endcase
    endfunction

    // Ticks until the selected output equals val; n is the number of edges taken.
    task automatic wait_until(input int sel, input logic val, input string tag, output int n);
        n = 0;
        while (sig_of(sel) !== val && n < 500) begin
            tick();
            n++;
        end
        if (sig_of(sel) !== val) check_val({tag, "_timeout"}, n, -1);
    endtask

    task automatic hold_reset(input logic locked);
        dcm_locked = locked;
        dcm_status = 8'h00;
        force_relock = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_idle_reset(input string tag);
        check_val({tag, "_dcm_reset"}, int'(dcm_reset), 1);
        check_val({tag, "_clk_ok"}, int'(clk_ok), 0);
        check_val({tag, "_sys_reset_n"}, int'(sys_reset_n), 0);
        check_val({tag, "_retry"}, int'(retry_cnt), 0);
        check_val({tag, "_fault"}, int'(fault), 0);
    endtask

    // From RUN: a one-cycle lock drop (kind 0) or CLKFX-stopped pulse (kind 1) forces a relock.
    task automatic relock(input string tag, input int kind);
        int n;
        sb_push(3);
        sb_push(8);
        sb_push(17);
        if (kind == 0) dcm_locked = 1'b0;
        else dcm_status[2] = 1'b1;
        tick();
        dcm_locked = 1'b1;
        dcm_status = 8'h00;
        wait_until(1, 1'b0, {tag, "_fall"}, n);
        sb_check({tag, "_clk_ok_fall_lat"}, n + 1);
        check_val({tag, "_sys_reset_n_low"}, int'(sys_reset_n), 0);
        check_val({tag, "_dcm_reset_on"}, int'(dcm_reset), 1);
        wait_until(0, 1'b0, {tag, "_hold"}, n);
        sb_check({tag, "_hold_len"}, n);
        wait_until(1, 1'b1, {tag, "_relock"}, n);
        sb_check({tag, "_relock_lat"}, n);
        check_val({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=%0d expected=%0d", n_checks, -1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, n2, bad;

        // 1. Nominal bring-up
        hold_reset(1'b0);
        check_idle_reset("rst");
        reset_n = 1'b1;
        sb_push(8);
        wait_until(0, 1'b0, "s1_hold", n);
        sb_check("s1_hold_len", n);
        repeat (12) tick();
        dcm_locked = 1'b1;
        sb_push(19);
        wait_until(1, 1'b1, "s1_lock", n);
        sb_check("s1_clk_ok_lat", n);
        check_val("s1_sys_reset_n", int'(sys_reset_n), 1);
        check_val("s1_retry", int'(retry_cnt), 0);
        check_val("s1_dcm_reset", int'(dcm_reset), 0);

        // 4. Lock loss in RUN, 5b. CLKFX stopped in RUN
        relock("s4", 0);
        relock("s5b", 1);

        // 2. Single timeout then lock
        hold_reset(1'b0);
        reset_n = 1'b1;
        sb_push(8);
        sb_push(100);
        wait_until(0, 1'b0, "s2_hold1", n);
        sb_check("s2_hold1_len", n);
        wait_until(0, 1'b1, "s2_wait", n);
        sb_check("s2_wait_len", n);
        check_val("s2_retry1", int'(retry_cnt), 1);
        dcm_locked = 1'b1;
        sb_push(8);
        sb_push(17);
        wait_until(0, 1'b0, "s2_hold2", n);
        sb_check("s2_hold2_len", n);
        check_val("s2_retry_pre", int'(retry_cnt), 1);
        wait_until(1, 1'b1, "s2_lock", n);
        sb_check("s2_clk_ok_lat", n);
        check_val("s2_retry_clr", int'(retry_cnt), 0);

        // 5a. Lock glitch during SETTLE
        hold_reset(1'b1);
        reset_n = 1'b1;
        sb_push(8);
        wait_until(0, 1'b0, "s5a_hold", n);
        sb_check("s5a_hold_len", n);
        repeat (10) tick();
        sb_push(3);
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        wait_until(0, 1'b1, "s5a_fail", n);
        sb_check("s5a_fail_lat", n + 1);
        check_val("s5a_clk_ok", int'(clk_ok), 0);
        check_val("s5a_retry", int'(retry_cnt), 1);
        check_val("s5a_fault", int'(fault), 0);
        sb_push(8);
        sb_push(17);
        wait_until(0, 1'b0, "s5a_hold2", n);
        sb_check("s5a_hold2_len", n);
        wait_until(1, 1'b1, "s5a_lock", n);
        sb_check("s5a_clk_ok_lat", n);
        check_val("s5a_retry_clr", int'(retry_cnt), 0);

        // 3. Permanent failure, FAULT, FORCE_RELOCK recovery
        hold_reset(1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_push(8);
            sb_push(100);
            wait_until(0, 1'b0, "s3_hold", n);
            sb_check($sformatf("s3_hold%0d_len", i), n);
            wait_until(0, 1'b1, "s3_wait", n);
            sb_check($sformatf("s3_wait%0d_len", i), n);
            check_val($sformatf("s3_retry%0d", i), int'(retry_cnt), i + 1);
            check_val($sformatf("s3_fault%0d", i), int'(fault), (i == 2) ? 1 : 0);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dcm_reset !== 1'b1 || fault !== 1'b1 || clk_ok !== 1'b0 || retry_cnt !== 4'd3)
                bad++;
        end
        check_val("s3_fail_held", bad, 0);
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check_val("s3_force_fault", int'(fault), 0);
        check_val("s3_force_retry", int'(retry_cnt), 0);
        check_val("s3_force_dcm_reset", int'(dcm_reset), 1);
        sb_push(8);
        wait_until(0, 1'b0, "s3_hold_new", n);
        sb_check("s3_hold_new_len", n);

        // 6. FORCE_RELOCK ignored in WAIT_LOCK; reset mid-sequence
        hold_reset(1'b0);
        reset_n = 1'b1;
        wait_until(0, 1'b0, "s6_hold", n);
        repeat (50) tick();
        sb_push(100);
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check_val("s6_force_ignored", int'(dcm_reset), 0);
        wait_until(0, 1'b1, "s6_wait", n2);
        sb_check("s6_wait_len", 51 + n2);
        check_val("s6_retry1", int'(retry_cnt), 1);
        wait_until(0, 1'b0, "s6_hold2", n);
        repeat (50) tick();
        reset_n = 1'b0;
        tick();
        check_idle_reset("s6_mid_rst");
        reset_n = 1'b1;
        tick();

        check_val("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
